// File: rtl/key_debounce_conditioner_if.sv
// Key conditioner signal bundle: raw pins and latch clears in,
// debounced levels, edge pulses and sticky press flags out.
interface key_debounce_conditioner_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] latch_clr;
    logic [NUM_KEYS-1:0] key_state;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_press_latched;

    modport master (
        output key_raw,
        output latch_clr,
        input  key_state,
        input  key_press,
        input  key_release,
        input  key_press_latched
    );

    modport slave (
        input  key_raw,
        input  latch_clr,
        output key_state,
        output key_press,
        output key_release,
        output key_press_latched
    );
endinterface

// File: rtl/key_debounce_conditioner.sv
// Per-key synchroniser, counter debounce, press/release pulses
// and a software-cleared sticky press flag for the key PIO.
module key_debounce_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 19,
    parameter int ACTIVE_LOW      = 1
) (
    input logic                      clk,
    input logic                      reset_n,
    key_debounce_conditioner_if.slave bus
);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam logic [NUM_KEYS-1:0] IDLE_LVL =
        (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE =
        CNT_WIDTH'(1);
    localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

    logic [NUM_KEYS-1:0]  sync1;
    logic [NUM_KEYS-1:0]  sync2;
    logic [NUM_KEYS-1:0]  pressed_sync;
    state_t               state_q [NUM_KEYS];
    state_t               state_d [NUM_KEYS];
    logic [CNT_WIDTH-1:0] cnt_q   [NUM_KEYS];
    logic [CNT_WIDTH-1:0] cnt_d   [NUM_KEYS];
    logic [NUM_KEYS-1:0]  press_d;
    logic [NUM_KEYS-1:0]  release_d;
    logic [NUM_KEYS-1:0]  level_d;
    logic [NUM_KEYS-1:0]  latched_d;

    assign pressed_sync = sync2 ^ IDLE_LVL;

    // Two-flop synchroniser, idles at the released pin level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= IDLE_LVL;
            sync2 <= IDLE_LVL;
        end else begin
            sync1 <= bus.key_raw;
            sync2 <= sync1;
        end
    end

    // Debounce FSM state and counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= RELEASED;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Next state: count stable cycles, drop back on any bounce
    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                RELEASED: begin
                    if (pressed_sync[i]) begin
                        state_d[i] = SINGLE ? PRESSED : PRESS_WAIT;
                        cnt_d[i]   = SINGLE ? '0 : CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed_sync[i]) begin
                        state_d[i] = RELEASED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!pressed_sync[i]) begin
                        state_d[i] = SINGLE ? RELEASED : RELEASE_WAIT;
                        cnt_d[i]   = SINGLE ? '0 : CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (pressed_sync[i]) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = RELEASED;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = RELEASED;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Outputs: pulses only on accepted transitions, not bounce returns
    always_comb begin
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            press_d[i] = (state_d[i] == PRESSED) &&
                         ((state_q[i] == RELEASED) ||
                          (state_q[i] == PRESS_WAIT));
            release_d[i] = (state_d[i] == RELEASED) &&
                           ((state_q[i] == PRESSED) ||
                            (state_q[i] == RELEASE_WAIT));
        end
        level_d   = (bus.key_state | press_d) & ~release_d;
        // Press seen this edge or last edge beats a clear strobe
        latched_d = press_d | bus.key_press |
                    (bus.key_press_latched & ~bus.latch_clr);
    end

    // Registered outputs so no input reaches an output combinationally
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.key_state         <= '0;
            bus.key_press         <= '0;
            bus.key_release       <= '0;
            bus.key_press_latched <= '0;
        end else begin
            bus.key_state         <= level_d;
            bus.key_press         <= press_d;
            bus.key_release       <= release_d;
            bus.key_press_latched <= latched_d;
        end
    end

endmodule
